cram_port_arbiter: RTL and testbench

//  Shares the single-port cart RAM (128 KB, byte wide, 1-cycle sync read) between three requesters:
//  CPU cart bus (A000-BFFF window, already MBC-translated), savestate CRAM copy engine, SD backup engine.

---
 rtl/cram_arb_pkg.sv | 9 +
 rtl/cram_port_arbiter.sv | 106 ++++++++++
 tb/tb_cram_port_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/cram_arb_pkg.sv
// Shared types and default widths for the cart RAM port arbiter.
package cram_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_SS = 2'd2, OWN_BK = 2'd3} owner_t;

  localparam int AW_DEF         = 17;
  localparam int DW_DEF         = 8;
  localparam int STARVE_W_DEF   = 4;
  localparam int STARVE_MAX_DEF = 15;
endpackage

// File: rtl/cram_port_arbiter.sv
// Single-port cart RAM arbiter: CPU never stalls, savestate beats backup,
// backup is promoted above savestate after STARVE_MAX refused cycles.
module cram_port_arbiter
  import cram_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_W   = STARVE_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ss_lock,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_ram_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_di,
  output logic [DW-1:0] cpu_do,
  output logic          cpu_dv,
  input  logic          ss_req,
  input  logic          ss_we,
  input  logic [AW-1:0] ss_addr,
  input  logic [DW-1:0] ss_di,
  output logic          ss_gnt,
  output logic [DW-1:0] ss_do,
  output logic          ss_dv,
  input  logic          bk_req,
  input  logic          bk_we,
  input  logic [AW-1:0] bk_addr,
  input  logic [DW-1:0] bk_di,
  output logic          bk_gnt,
  output logic [DW-1:0] bk_do,
  output logic          bk_dv,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  input  logic [DW-1:0] ram_q
);

  owner_t                win;
  owner_t                tag_pipe [2];
  logic [STARVE_W-1:0]   wait_cnt;
  logic [AW-1:0]         win_addr;
  logic [DW-1:0]         win_di;
  logic                  win_we;
  logic                  cpu_take;
  logic                  bk_urgent;

  // rd+wr counts as a write; a write with RAM disabled frees the slot
  assign cpu_take  = ~ss_lock & (cpu_wr ? cpu_ram_en : cpu_rd);
  assign bk_urgent = bk_req & ~ss_lock & (wait_cnt == STARVE_W'(STARVE_MAX));

  always_comb begin
    win = OWN_NONE;
    if (cpu_take)       win = OWN_CPU;
    else if (bk_urgent) win = OWN_BK;
    else if (ss_req)    win = OWN_SS;
    else if (bk_req)    win = OWN_BK;
  end

  always_comb begin
    win_addr = '0;
    win_di   = '0;
    win_we   = 1'b0;
    case (win)
      OWN_CPU: begin win_addr = cpu_addr; win_di = cpu_di; win_we = cpu_wr; end
      OWN_SS:  begin win_addr = ss_addr;  win_di = ss_di;  win_we = ss_we;  end
      OWN_BK:  begin win_addr = bk_addr;  win_di = bk_di;  win_we = bk_we;  end
      default: ;
    endcase
  end

  assign ss_gnt = (win == OWN_SS);
  assign bk_gnt = (win == OWN_BK);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr    <= '0;
      ram_di      <= '0;
      ram_we      <= 1'b0;
      tag_pipe[0] <= OWN_NONE;
      tag_pipe[1] <= OWN_NONE;
      wait_cnt    <= '0;
    end else begin
      ram_we <= (win != OWN_NONE) & win_we;
      if (win != OWN_NONE) begin
        ram_addr <= win_addr;
        ram_di   <= win_di;
      end
      tag_pipe[0] <= (win != OWN_NONE && !win_we) ? win : OWN_NONE;
      tag_pipe[1] <= tag_pipe[0];
      if (!bk_req || bk_gnt)                          wait_cnt <= '0;
      else if (wait_cnt != STARVE_W'(STARVE_MAX))     wait_cnt <= wait_cnt + STARVE_W'(1);
    end
  end

  // ram_q lands two cycles after accept; route it by the aged owner tag
  assign cpu_dv = (tag_pipe[1] == OWN_CPU);
  assign ss_dv  = (tag_pipe[1] == OWN_SS);
  assign bk_dv  = (tag_pipe[1] == OWN_BK);
  assign cpu_do = cpu_dv ? ram_q : '0;
  assign ss_do  = ss_dv  ? ram_q : '0;
  assign bk_do  = bk_dv  ? ram_q : '0;

endmodule

// File: tb/tb_cram_port_arbiter.sv
// Scoreboard bench for cram_port_arbiter with a behavioural RAM and arbitration model.
module tb_cram_port_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ss_lock, cpu_rd, cpu_wr, cpu_ram_en;
  logic [16:0] cpu_addr, ss_addr, bk_addr, ram_addr;
  logic [7:0]  cpu_di, ss_di, bk_di, ram_di, ram_q;
  logic [7:0]  cpu_do, ss_do, bk_do;
  logic        cpu_dv, ss_dv, bk_dv, ss_req, ss_we, ss_gnt, bk_req, bk_we, bk_gnt, ram_we;

  cram_port_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ss_lock(ss_lock),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_ram_en(cpu_ram_en), .cpu_addr(cpu_addr),
    .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_dv(cpu_dv),
    .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_di(ss_di),
    .ss_gnt(ss_gnt), .ss_do(ss_do), .ss_dv(ss_dv),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_di(bk_di),
    .bk_gnt(bk_gnt), .bk_do(bk_do), .bk_dv(bk_dv),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_di(ram_di), .ram_q(ram_q)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic lock, rd, wr, en; logic [16:0] ca; logic [7:0] cd;
    logic sr, sw; logic [16:0] sa; logic [7:0] sd;
    logic br, bw; logic [16:0] ba; logic [7:0] bd;
  } stim_t;
  typedef struct { int own; logic [7:0] data; int due; } exp_t;

  logic [7:0] mem     [0:131071];
  logic [7:0] ref_mem [0:131071];
  exp_t  q[$];
  stim_t st;
  int    checks = 0, errors = 0, cyc = 0, age = 0;
  logic  pend_valid = 1'b0, pend_we, pend_rd;
  logic [16:0] pend_addr;
  logic [7:0]  pend_di;
  logic  last_ss_gnt, last_bk_gnt;

  // behavioural single-port sync RAM
  always @(posedge clk_sys) begin
    ram_q <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_di;
  end
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // one dv at most per cycle, so one ordered queue covers all three ports
  always @(negedge clk_sys) begin
    exp_t e;
    logic [7:0] d;
    if (cpu_dv | ss_dv | bk_dv) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_dv: got %b expected none (cycle %0d)", {cpu_dv, ss_dv, bk_dv}, cyc);
      end else begin
        e = q.pop_front();
        d = cpu_dv ? cpu_do : ss_dv ? ss_do : bk_do;
        checks++;
        if ({cpu_dv, ss_dv, bk_dv} != 3'(4 >> (e.own - 1)) || d !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL read_data: got dv=%b do=%h cyc=%0d expected owner=%0d do=%h cyc=%0d",
                   {cpu_dv, ss_dv, bk_dv}, d, cyc, e.own, e.data, e.due);
        end
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++; errors++;
      $display("FAIL missing_dv: got none expected owner=%0d do=%h at cycle %0d", e.own, e.data, e.due);
    end
  end

  task automatic apply();
    ss_lock = st.lock; cpu_rd = st.rd; cpu_wr = st.wr; cpu_ram_en = st.en;
    cpu_addr = st.ca; cpu_di = st.cd;
    ss_req = st.sr; ss_we = st.sw; ss_addr = st.sa; ss_di = st.sd;
    bk_req = st.br; bk_we = st.bw; bk_addr = st.ba; bk_di = st.bd;
  endtask

  task automatic idle();
    st = '{default: '0};
  endtask

  // one bus cycle: check last cycle's RAM drive, apply stimulus, predict and check grants
  task automatic step();
    int w; logic we; logic [16:0] a; logic [7:0] d; logic cpu_real;
    @(posedge clk_sys); #1;
    if (pend_valid) begin
      chk("ram_we", 32'(ram_we), 32'(pend_we));
      if (pend_we || pend_rd) chk("ram_addr", 32'(ram_addr), 32'(pend_addr));
      if (pend_we) chk("ram_di", 32'(ram_di), 32'(pend_di));
    end
    apply();
    cpu_real = !st.lock && (st.wr ? st.en : st.rd);
    w = 0;
    if (cpu_real) w = 1;
    else if (!st.lock && st.br && age >= 15) w = 3;
    else if (st.sr) w = 2;
    else if (st.br) w = 3;
    we = 0; a = 0; d = 0;
    if (w == 1) begin we = st.wr; a = st.ca; d = st.cd; end
    if (w == 2) begin we = st.sw; a = st.sa; d = st.sd; end
    if (w == 3) begin we = st.bw; a = st.ba; d = st.bd; end
    #3;
    chk("ss_gnt", 32'(ss_gnt), 32'(w == 2));
    chk("bk_gnt", 32'(bk_gnt), 32'(w == 3));
    if (w != 0) begin
      if (we) ref_mem[a] = d;
      else q.push_back('{own: w, data: ref_mem[a], due: cyc + 2});
    end
    pend_valid = 1'b1; pend_we = (w != 0) && we; pend_rd = (w != 0) && !we;
    pend_addr = a; pend_di = d;
    age = (st.br && w != 3) ? ((age < 15) ? age + 1 : 15) : 0;
    last_ss_gnt = (w == 2); last_bk_gnt = (w == 3);
  endtask

  task automatic do_reset();
    @(posedge clk_sys); #2;
    idle(); apply();
    reset_n = 1'b0;
    #1;
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_we",   32'(ram_we), 0);
    chk("rst_ram_di",   32'(ram_di), 0);
    chk("rst_dv",       32'({cpu_dv, ss_dv, bk_dv}), 0);
    chk("rst_do",       32'({cpu_do, ss_do, bk_do}), 0);
    q.delete(); age = 0; pend_valid = 1'b0;
    repeat (2) @(posedge clk_sys);
    #2 reset_n = 1'b1;
  endtask

  task automatic rand_addr(output logic [16:0] a);
    a = 17'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) a = 17'h1FFF0 + a;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 131072; i++) begin
      mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = mem[i];
    end
    mem[17'h0A55] = 8'h3C; ref_mem[17'h0A55] = 8'h3C;
    idle(); apply();
    #12;
    chk("init_ram_we", 32'(ram_we), 0);
    chk("init_ram_addr", 32'(ram_addr), 0);
    chk("init_dv", 32'({cpu_dv, ss_dv, bk_dv}), 0);
    reset_n = 1'b1;
    idle(); step();

    // savestate read in flight when reset hits: no ss_dv afterwards
    idle(); st.sr = 1; st.sa = 17'h00010; step();
    do_reset();
    idle(); repeat (3) step();

    // CPU read with known RAM content
    idle(); st.rd = 1; st.ca = 17'h0A55; step();
    idle(); repeat (3) step();

    // CPU write collides with savestate read of same address
    idle(); st.wr = 1; st.en = 1; st.ca = 17'h20; st.cd = 8'hA7; st.sr = 1; st.sa = 17'h20; step();
    st.wr = 0; step();
    idle(); repeat (3) step();

    // disabled CPU write frees the slot for backup; RAM at cpu_addr untouched
    idle(); st.wr = 1; st.en = 0; st.ca = 17'h30; st.cd = 8'hFF;
    st.br = 1; st.bw = 1; st.ba = 17'h31; st.bd = 8'h11; step();
    idle(); st.rd = 1; st.ca = 17'h30; step();
    idle(); repeat (3) step();

    // savestate hogs the port: backup must win after exactly 15 refused cycles
    n = 0;
    do begin
      idle(); st.sr = 1; st.sa = 17'($urandom_range(0, 15)); st.br = 1; st.ba = 17'h40;
      step(); n++;
    end while (!bk_gnt && n < 40);
    chk("starve_wait", 32'(n - 1), 15);
    idle(); st.sr = 1; st.sa = 17'h41; step();
    chk("ss_resumes", 32'(ss_gnt), 1);
    idle(); repeat (3) step();

    // savestate lock: CPU ignored, savestate reads top address
    idle(); st.lock = 1; st.rd = 1; st.ca = 17'h5; st.sr = 1; st.sa = 17'h1FFFF; step();
    idle(); st.lock = 1; repeat (3) step();

    // randomized traffic
    idle();
    for (int i = 0; i < 3000; i++) begin
      int r;
      if ($urandom_range(0, 49) == 0) st.lock = ~st.lock;
      r = $urandom_range(0, 9);
      st.rd = (r <= 1) || (r == 3);
      st.wr = (r == 2) || (r == 3);
      st.en = ($urandom_range(0, 4) != 0);
      rand_addr(st.ca); st.cd = 8'($urandom);
      if (!st.sr || last_ss_gnt) begin
        st.sr = ($urandom_range(0, 2) != 0); st.sw = $urandom_range(0, 1) == 1;
        rand_addr(st.sa); st.sd = 8'($urandom);
      end
      if (!st.br || last_bk_gnt) begin
        st.br = ($urandom_range(0, 1) != 0); st.bw = $urandom_range(0, 1) == 1;
        rand_addr(st.ba); st.bd = 8'($urandom);
      end
      step();
    end
    idle(); repeat (4) step();
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
